// File: rtl/onehot_dec_seq.sv
// rtl/onehot_dec_seq.sv - FIFO-buffered code-to-one-hot decoder with hold timer; optional self-check under DEC_CHECK_EN
//
// Codes arrive over a valid/ready handshake into a small FIFO. Each code is shown
// as a one-hot word on y for HOLD_CYCLES cycles (legal 1..255). Consecutive words
// follow each other with no zero gap. done pulses once when the queue drains.
// FIFO_DEPTH must be a power of two, minimum 2.
// Define DEC_CHECK_EN to build the re-encoding checker behind chk_err.
module onehot_dec_seq #(
  parameter int CODE_W      = 3,
  parameter int HOLD_CYCLES = 4,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CODE_W-1:0]             in_code,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [(2**CODE_W)-1:0]        y,
  output logic                          y_valid,
  output logic                          done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          chk_err
);

  localparam int OUT_W = 2**CODE_W;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [7:0]       HOLD_LOAD = 8'(HOLD_CYCLES - 1);
  localparam logic [OUT_W-1:0] ONE_BIT   = OUT_W'(1);

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  state_t            state;
  logic [CODE_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [7:0]        timer;
  logic              push;
  logic              pop;
  logic              not_empty;
  logic [CODE_W-1:0] head;

  // Ready only depends on the registered count, so a pop in the same cycle
  // never opens a slot early; held low for as long as reset is asserted.
  assign not_empty = (fifo_count != '0);
  assign in_ready  = !rst && (fifo_count < DEPTH_C);
  assign push      = in_valid && in_ready;
  // In IDLE the timer is always zero, so one condition covers both the
  // first load from IDLE and the back-to-back reload at the end of a hold.
  assign pop       = not_empty && ((state == IDLE) || (timer == 8'd0));
  assign head      = mem[rd_ptr];

  // Storage write: only a real transfer touches the array, so an undriven
  // in_code outside a handshake can never reach the output path.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_code;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        fifo_count <= fifo_count + CNT_W'(1);
      end else if (pop && !push) begin
        fifo_count <= fifo_count - CNT_W'(1);
      end
    end
  end

  // Output sequencer: loads a word, counts down its hold, then chains or drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      y       <= '0;
      y_valid <= 1'b0;
      done    <= 1'b0;
      timer   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            y       <= ONE_BIT << head;
            y_valid <= 1'b1;
            timer   <= HOLD_LOAD;
            state   <= HOLD;
          end else begin
            y       <= '0;
            y_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (timer != 8'd0) begin
            timer <= timer - 8'd1;
          end else if (pop) begin
            y       <= ONE_BIT << head;
            y_valid <= 1'b1;
            timer   <= HOLD_LOAD;
          end else begin
            y       <= '0;
            y_valid <= 1'b0;
            done    <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef DEC_CHECK_EN
  logic [CODE_W-1:0] cur_code;
  logic [CODE_W-1:0] enc;
  logic [CODE_W:0]   ones;

  // Remember the code behind the word currently on y, for comparison.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_code <= '0;
    end else if (pop) begin
      cur_code <= head;
    end
  end

  // Re-encode y (highest set bit wins) and count its set bits.
  always_comb begin
    enc  = '0;
    ones = '0;
    for (int i = 0; i < OUT_W; i++) begin
      if (y[i]) begin
        enc  = CODE_W'(i);
        ones = ones + (CODE_W+1)'(1);
      end
    end
  end

  // Sticky error: a shown word that is not one-hot or does not match its code.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_err <= 1'b0;
    end else if (y_valid && ((enc != cur_code) || (ones != (CODE_W+1)'(1)))) begin
      chk_err <= 1'b1;
    end
  end
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_onehot_dec_seq.sv
// tb/tb_onehot_dec_seq.sv - self-checking bench for onehot_dec_seq (DEC_CHECK_EN adds the checker sequence)
module tb_onehot_dec_seq;

  localparam int HOLD  = 4;
  localparam int DEPTH = 4;

  logic       clk;
  logic       rst;
  logic [2:0] in_code;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] y;
  logic       y_valid;
  logic       done;
  logic [2:0] fifo_count;
  logic       chk_err;

  onehot_dec_seq #(
    .CODE_W(3),
    .HOLD_CYCLES(HOLD),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_code(in_code),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .y(y),
    .y_valid(y_valid),
    .done(done),
    .fifo_count(fifo_count),
    .chk_err(chk_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model: pending codes, word on display (-1 = none), cycles left to show it.
  int mq[$];
  int cur = -1;
  int left = 0;
  bit done_exp = 0;
  bit last_acc = 0;
  int pre_count = 0;

  typedef struct {
    logic [2:0] code;
    logic [7:0] exp_y;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    mq.delete();
    cur = -1;
    left = 0;
    done_exp = 0;
  endtask

  // One clock of stimulus, with the model stepped and all outputs compared afterwards.
  task automatic cycle(input logic v, input logic [2:0] c);
    bit push_ok;
    in_valid = v;
    in_code  = c;
    push_ok  = v && (mq.size() < DEPTH);
    chk("in_ready", int'(in_ready), int'(mq.size() < DEPTH));
    pre_count = int'(fifo_count);
    @(posedge clk);
    done_exp = 0;
    if (cur >= 0 && left > 1) begin
      left--;
    end else if (mq.size() > 0) begin
      cur  = mq.pop_front();
      left = HOLD;
    end else if (cur >= 0) begin
      cur = -1;
      left = 0;
      done_exp = 1;
    end
    if (push_ok) mq.push_back(int'(c));
    last_acc = push_ok;
    #1;
    chk("y", int'(y), (cur < 0) ? 0 : (1 << cur));
    chk("y_valid", int'(y_valid), int'(cur >= 0));
    chk("done", int'(done), int'(done_exp));
    chk("fifo_count", int'(fifo_count), mq.size());
    chk("chk_err", int'(chk_err), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int maxc;
    bit saw_full_pop;
    logic [7:0] prev;
    logic [7:0] obs[$];
    logic [7:0] seq_exp[14];
    int dens[5];
    logic [7:0] fv;

    tbl[0] = '{3'd0, 8'h01};
    tbl[1] = '{3'd1, 8'h02};
    tbl[2] = '{3'd2, 8'h04};
    tbl[3] = '{3'd3, 8'h08};
    tbl[4] = '{3'd4, 8'h10};
    tbl[5] = '{3'd5, 8'h20};
    tbl[6] = '{3'd6, 8'h40};
    tbl[7] = '{3'd7, 8'h80};

    rst = 1'b1;
    in_valid = 1'b0;
    in_code = 3'd0;
    #1;
    chk("rst_y", int'(y), 0);
    chk("rst_y_valid", int'(y_valid), 0);
    chk("rst_count", int'(fifo_count), 0);
    chk("rst_ready", int'(in_ready), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_chk_err", int'(chk_err), 0);
    #22;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_rst", int'(in_ready), 1);

    // Table: each code alone, one-hot word after one edge, cleared after the hold
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, tbl[i].code);
      for (int k = 1; k <= HOLD + 1; k++) begin
        cycle(1'b0, 3'd0);
        if (k == 1) chk("tbl_y", int'(y), int'(tbl[i].exp_y));
        if (k == HOLD + 1) begin
          chk("tbl_idle_y", int'(y), 0);
          chk("tbl_done", int'(done), 1);
        end
      end
    end

    // Single code 2: held exactly HOLD cycles, then idle with one done pulse
    cycle(1'b1, 3'd2);
    for (int k = 0; k < HOLD; k++) begin
      cycle(1'b0, 3'd0);
      chk("single_hold", int'(y), 8'h04);
    end
    cycle(1'b0, 3'd0);
    chk("single_end_y", int'(y), 0);
    chk("single_done", int'(done), 1);
    cycle(1'b0, 3'd0);
    chk("single_done_clr", int'(done), 0);

    // Back-to-back 0,7,5: no zero gap between words, done only after the last
    for (int k = 1; k <= 13; k++)
      seq_exp[k] = (k <= 4) ? 8'h01 : (k <= 8) ? 8'h80 : (k <= 12) ? 8'h20 : 8'h00;
    cycle(1'b1, 3'd0);
    for (int k = 1; k <= 13; k++) begin
      if (k == 1) cycle(1'b1, 3'd7);
      else if (k == 2) cycle(1'b1, 3'd5);
      else cycle(1'b0, 3'd0);
      chk("b2b_y", int'(y), int'(seq_exp[k]));
      chk("b2b_done", int'(done), int'(k == 13));
    end
    cycle(1'b0, 3'd0);

    // Backpressure: in_valid held high with codes 1..6
    idx = 1;
    maxc = 0;
    saw_full_pop = 0;
    prev = 8'h00;
    for (int k = 0; k < 40; k++) begin
      cycle(idx <= 6, 3'(idx));
      if (last_acc) idx++;
      if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
      if (pre_count == DEPTH && in_valid && int'(fifo_count) == DEPTH - 1) saw_full_pop = 1;
      if (y_valid && y != prev) obs.push_back(y);
      prev = y;
    end
    chk("bp_all_pushed", idx, 7);
    chk("bp_max_count", maxc, DEPTH);
    chk("bp_full_pop_seen", int'(saw_full_pop), 1);
    chk("bp_word_count", obs.size(), 6);
    for (int i = 0; i < obs.size() && i < 6; i++)
      chk("bp_order", int'(obs[i]), 1 << (i + 1));

    // Reset mid-stream: y=0x10 with two codes buffered
    cycle(1'b1, 3'd4);
    cycle(1'b1, 3'd1);
    cycle(1'b1, 3'd2);
    chk("mid_y_pre", int'(y), 8'h10);
    chk("mid_count_pre", int'(fifo_count), 2);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_y", int'(y), 0);
    chk("mid_rst_y_valid", int'(y_valid), 0);
    chk("mid_rst_count", int'(fifo_count), 0);
    chk("mid_rst_ready", int'(in_ready), 0);
    model_reset();
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_ready_after", int'(in_ready), 1);
    chk("mid_no_done", int'(done), 0);
    chk("mid_y_after", int'(y), 0);
    for (int k = 0; k < 3; k++) cycle(1'b0, 3'd0);

    // Random traffic at several densities against the model
    dens[0] = 90; dens[1] = 50; dens[2] = 20; dens[3] = 100; dens[4] = 10;
    for (int b = 0; b < 5; b++)
      for (int k = 0; k < 100; k++)
        cycle($urandom_range(0, 99) < dens[b], 3'($urandom_range(0, 7)));
    for (int k = 0; k < 30; k++) cycle(1'b0, 3'd0);

`ifdef DEC_CHECK_EN
    // Corrupt one bit of the shown word: the error must appear and stay until reset
    cycle(1'b1, 3'd3);
    cycle(1'b0, 3'd0);
    chk("chk_pre", int'(chk_err), 0);
    fv = y ^ 8'h02;
    force dut.y = fv;
    @(posedge clk);
    #1;
    chk("chk_set", int'(chk_err), 1);
    release dut.y;
    repeat (6) @(posedge clk);
    #1;
    chk("chk_sticky", int'(chk_err), 1);
    rst = 1'b1;
    #1;
    chk("chk_rst_clear", int'(chk_err), 0);
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    cycle(1'b0, 3'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
